// File: rtl/aes_pkg.sv
// Shared AES definitions: state type, GF(2^8) helpers, InvMixColumns coefficients, byte indexing.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_NR      = 10;

    // InvMixColumns circulant coefficients
    localparam logic [7:0] GF_09 = 8'h09;
    localparam logic [7:0] GF_0B = 8'h0b;
    localparam logic [7:0] GF_0D = 8'h0d;
    localparam logic [7:0] GF_0E = 8'h0e;

    typedef logic [AES_STATE_W-1:0] state_t;

    // Occupancy of one elastic slot
    typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

    // Multiply by x modulo 0x11B
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; constant c folds this into a few XORs
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = b;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    // Byte 0 sits in the top bits of the state
    function automatic int unsigned byte_msb(input int unsigned idx);
        return AES_STATE_W - 1 - 8 * idx;
    endfunction

endpackage

// File: rtl/inv_round_stage_if.sv
// Valid/ready stream carrying one AES state plus round key, last-round flag and sideband tag.
interface inv_round_stage_if #(
    parameter int unsigned TAG_W = 4
);
    import aes_pkg::*;

    logic             valid;
    logic             ready;
    state_t           state;
    state_t           key;    // only meaningful on the input side
    logic             last;
    logic [TAG_W-1:0] tag;

    modport master (output valid, state, key, last, tag, input ready);
    modport slave  (input valid, state, key, last, tag, output ready);

endinterface

// File: rtl/inv_Mix_columns.sv
// Combinational InvMixColumns over all four columns of the state.
module inv_Mix_columns
    import aes_pkg::*;
(
    input  state_t in_i,
    output state_t out_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        localparam int unsigned Msb0 = byte_msb(4 * c);
        localparam int unsigned Msb1 = byte_msb(4 * c + 1);
        localparam int unsigned Msb2 = byte_msb(4 * c + 2);
        localparam int unsigned Msb3 = byte_msb(4 * c + 3);

        logic [7:0] a0, a1, a2, a3;
        assign a0 = in_i[Msb0 -: 8];
        assign a1 = in_i[Msb1 -: 8];
        assign a2 = in_i[Msb2 -: 8];
        assign a3 = in_i[Msb3 -: 8];

        assign out_o[Msb0 -: 8] = gf_mul(a0, GF_0E) ^ gf_mul(a1, GF_0B)
                                ^ gf_mul(a2, GF_0D) ^ gf_mul(a3, GF_09);
        assign out_o[Msb1 -: 8] = gf_mul(a0, GF_09) ^ gf_mul(a1, GF_0E)
                                ^ gf_mul(a2, GF_0B) ^ gf_mul(a3, GF_0D);
        assign out_o[Msb2 -: 8] = gf_mul(a0, GF_0D) ^ gf_mul(a1, GF_09)
                                ^ gf_mul(a2, GF_0E) ^ gf_mul(a3, GF_0B);
        assign out_o[Msb3 -: 8] = gf_mul(a0, GF_0B) ^ gf_mul(a1, GF_0D)
                                ^ gf_mul(a2, GF_09) ^ gf_mul(a3, GF_0E);
    end

endmodule

// File: rtl/inv_round_slot.sv
// Elastic slot: output register plus one skid register; ready comes straight from a flop.
module inv_round_slot
    import aes_pkg::*;
#(
    parameter int unsigned Width = 133
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    occ_e             occ_q, occ_d;
    logic [Width-1:0] main_q, main_d;
    logic [Width-1:0] skid_q, skid_d;
    logic             push, pop;

    assign in_ready_o  = (occ_q != StTwo);
    assign out_valid_o = (occ_q != StEmpty);
    assign out_data_o  = main_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_ready_i && out_valid_o;

    // Occupancy and payload registers; reset discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= StEmpty;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Next occupancy; main is only rewritten when empty or being accepted, so it stays stable
    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        unique case (occ_q)
            StEmpty: begin
                if (push) begin
                    main_d = in_data_i;
                    occ_d  = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    main_d = in_data_i;
                end else if (push) begin
                    skid_d = in_data_i;
                    occ_d  = StTwo;
                end else if (pop) begin
                    occ_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    main_d = skid_q;
                    occ_d  = StOne;
                end
            end
            default: occ_d = StEmpty;
        endcase
    end

endmodule

// File: rtl/inv_round_stage.sv
// Back half of an AES-128 decryption round: AddRoundKey, then InvMixColumns unless last round.
// Define INV_ROUND_PIPE2_EN to register the AddRoundKey result before InvMixColumns.
module inv_round_stage
    import aes_pkg::*;
#(
    parameter int unsigned TAG_W = 4  // must match the interfaces' TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_round_stage_if.slave     in_if,
    inv_round_stage_if.master    out_if
);

    localparam int unsigned PW = AES_STATE_W + 1 + TAG_W;

    state_t           ark;
    state_t           mix_in;
    state_t           mix_out;
    state_t           res;
    logic             mix_last;
    logic [TAG_W-1:0] mix_tag;
    logic             mix_valid;
    logic             mix_ready;
    logic [PW-1:0]    out_data;

    assign ark = in_if.state ^ in_if.key;

`ifdef INV_ROUND_PIPE2_EN
    logic [PW-1:0] ark_data;

    inv_round_slot #(.Width(PW)) u_slot_ark (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_if.valid),
        .in_ready_o  (in_if.ready),
        .in_data_i   ({ark, in_if.last, in_if.tag}),
        .out_valid_o (mix_valid),
        .out_ready_i (mix_ready),
        .out_data_o  (ark_data)
    );

    assign mix_in   = ark_data[PW-1 -: AES_STATE_W];
    assign mix_last = ark_data[TAG_W];
    assign mix_tag  = ark_data[TAG_W-1:0];
`else
    assign mix_in      = ark;
    assign mix_last    = in_if.last;
    assign mix_tag     = in_if.tag;
    assign mix_valid   = in_if.valid;
    assign in_if.ready = mix_ready;
`endif

    inv_Mix_columns u_mix (
        .in_i  (mix_in),
        .out_o (mix_out)
    );

    assign res = mix_last ? mix_in : mix_out;

    inv_round_slot #(.Width(PW)) u_slot_out (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (mix_valid),
        .in_ready_o  (mix_ready),
        .in_data_i   ({res, mix_last, mix_tag}),
        .out_valid_o (out_if.valid),
        .out_ready_i (out_if.ready),
        .out_data_o  (out_data)
    );

    assign out_if.state = out_data[PW-1 -: AES_STATE_W];
    assign out_if.last  = out_data[TAG_W];
    assign out_if.tag   = out_data[TAG_W-1:0];
    assign out_if.key   = '0;  // no key travels downstream

endmodule
